reg_file_init: RTL and testbench

- Parametrised successor to the 8x8 register file: configurable data width and depth, two combinational read ports, one clocked write port.
- Adds a hardware init sequencer that loads a constant table (reg i = i for i < NINIT, else 0) after reset.
- Provides a ready flag, a write-drop indicator and an optional read-zero register 0.
- Sits between the decoder (addresses) and the ALU/writeback mux (data).

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_init_seq.sv | 62 ++++++
 rtl/reg_file_init.sv | 102 ++++++++++
 tb/tb_reg_file_init.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types, default sizes and the init-table function for the register file.
package reg_file_pkg;

  typedef enum logic {INIT, RUN} rf_state_t;

  localparam int unsigned RF_DW    = 8;
  localparam int unsigned RF_AW    = 3;
  localparam int unsigned RF_NINIT = 6;

  // Init table: the low ninit registers hold their own index, the rest hold 0.
  function automatic int unsigned init_val(input int unsigned idx, input int unsigned ninit);
    return (idx < ninit) ? idx : 32'd0;
  endfunction

endpackage

// File: rtl/reg_file_init_seq.sv
// Init sequencer: walks every register after reset, writing the constant table,
// then raises ready and idles in RUN until the next reset.
module reg_file_init_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned DW    = RF_DW,
  parameter int unsigned AW    = RF_AW,
  parameter int unsigned NINIT = RF_NINIT
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ready,
  output logic          init_we_c,
  output logic [AW-1:0] init_addr_c,
  output logic [DW-1:0] init_data_c
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned PW    = AW + 1;

  rf_state_t     state_q, state_d;
  logic [PW-1:0] init_ptr_q, init_ptr_d;
  logic          ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ready_q    <= ready_d;
    end
  end

  // The reset gate on init_we_c keeps the storage untouched on the reset edge.
  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    ready_d     = ready_q;
    init_we_c   = 1'b0;
    init_addr_c = init_ptr_q[AW-1:0];
    init_data_c = DW'(init_val(32'(init_ptr_q), NINIT));
    case (state_q)
      INIT: begin
        init_we_c  = !reset;
        init_ptr_d = init_ptr_q + PW'(1);
        if (init_ptr_q == PW'(DEPTH - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
  end

  assign ready = ready_q;

endmodule

// File: rtl/reg_file_init.sv
// Parametrised register file: two combinational read ports, one clocked write
// port, hardware init after reset. Optional macro REG_FILE_BYPASS_EN adds
// same-cycle write-through forwarding to both read ports.
module reg_file_init
  import reg_file_pkg::*;
#(
  parameter int unsigned DW      = RF_DW,
  parameter int unsigned AW      = RF_AW,
  parameter int unsigned NINIT   = RF_NINIT,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          ready,
  output logic          wr_drop
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam bit          ZR    = (ZERO_R0 != 0);

  logic [DW-1:0] core_q [DEPTH];
  logic [DW-1:0] core_d [DEPTH];
  logic          wr_drop_q, wr_drop_d;
  logic          init_we_c;
  logic [AW-1:0] init_addr_c;
  logic [DW-1:0] init_data_c;
  logic          r0_hit_c;
  logic          fwd_ok_c;
  logic          user_we_c;

  reg_file_init_seq #(
    .DW    (DW),
    .AW    (AW),
    .NINIT (NINIT)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .ready       (ready),
    .init_we_c   (init_we_c),
    .init_addr_c (init_addr_c),
    .init_data_c (init_data_c)
  );

  // A user write lands only in RUN and never to a hard-wired zero register.
  assign r0_hit_c  = ZR && (wr_addr == '0);
  assign fwd_ok_c  = wr_en && ready && !r0_hit_c;
  assign user_we_c = fwd_ok_c && !reset;

  always_comb begin
    core_d = core_q;
    if (init_we_c) begin
      core_d[init_addr_c] = init_data_c;
    end else if (user_we_c) begin
      core_d[wr_addr] = dat_in;
    end
  end

  always_ff @(posedge clk) begin
    core_q <= core_d;
  end

  always_comb begin
    wr_drop_d = wr_en && (!ready || r0_hit_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  assign wr_drop = wr_drop_q;

  // Read muxes: not-ready zeroing wins over r0 zeroing, which wins over forwarding.
  always_comb begin
    datA_out = core_q[rd_addrA];
`ifdef REG_FILE_BYPASS_EN
    if (fwd_ok_c && (wr_addr == rd_addrA)) datA_out = dat_in;
`endif
    if (ZR && (rd_addrA == '0)) datA_out = '0;
    if (!ready) datA_out = '0;
  end

  always_comb begin
    datB_out = core_q[rd_addrB];
`ifdef REG_FILE_BYPASS_EN
    if (fwd_ok_c && (wr_addr == rd_addrB)) datB_out = dat_in;
`endif
    if (ZR && (rd_addrB == '0)) datB_out = '0;
    if (!ready) datB_out = '0;
  end

endmodule

// File: tb/tb_reg_file_init.sv
// Bench for reg_file_init: directed scenarios plus randomized traffic against a
// behavioural model; a second instance covers the read-zero register 0 option.
module tb_reg_file_init;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       reset, wr_en;
  logic [2:0] wr_addr, rd_addrA, rd_addrB;
  logic [7:0] dat_in, datA_out, datB_out;
  logic       ready, wr_drop;

  logic       z_reset, z_wr_en;
  logic [2:0] z_wr_addr, z_rd_a, z_rd_b;
  logic [7:0] z_dat_in, z_datA, z_datB;
  logic       z_ready, z_drop;

  int n_tests = 0;
  int n_fail  = 0;

  reg_file_init #(.DW(8), .AW(3), .NINIT(6), .ZERO_R0(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(datA_out), .datB_out(datB_out),
    .ready(ready), .wr_drop(wr_drop)
  );

  reg_file_init #(.DW(8), .AW(3), .NINIT(6), .ZERO_R0(1)) dut_z (
    .clk(clk), .reset(z_reset), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .dat_in(z_dat_in),
    .rd_addrA(z_rd_a), .rd_addrB(z_rd_b), .datA_out(z_datA), .datB_out(z_datB),
    .ready(z_ready), .wr_drop(z_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts post-reset edges and keeps a plain array of contents.
  int         init_cnt = 0;
  bit         m_ready  = 1'b0;
  bit         m_drop   = 1'b0;
  logic [7:0] m_mem [8];

  always @(posedge clk) begin
    if (reset) begin
      init_cnt = 0;
      m_ready  = 1'b0;
      m_drop   = 1'b0;
    end else if (!m_ready) begin
      m_mem[init_cnt] = (init_cnt < 6) ? 8'(init_cnt) : 8'd0;
      m_drop   = wr_en;
      init_cnt = init_cnt + 1;
      if (init_cnt == 8) m_ready = 1'b1;
    end else begin
      m_drop = 1'b0;
      if (wr_en) m_mem[wr_addr] = dat_in;
    end
  end

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    if (!m_ready) return 8'd0;
    if (BYP && wr_en && (wr_addr == a)) return dat_in;
    return m_mem[a];
  endfunction

  task automatic do_init();
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] tbl [8];
    tbl = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0};
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
    n_tests++;
    if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      rd_addrA = 3'($urandom); rd_addrB = 3'($urandom);
      #1;
      n_tests++;
      if (datA_out !== 8'd0 || datB_out !== 8'd0) begin
        n_fail++; $display("FAIL init_read_zero k=%0d got=%h/%h exp=00/00", k, datA_out, datB_out);
      end
      @(negedge clk);
      n_tests++;
      if (ready !== (k == 8)) begin n_fail++; $display("FAIL init_ready k=%0d got=%b exp=%b", k, ready, k == 8); end
    end
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      rd_addrA = 3'(a); rd_addrB = 3'(7 - a);
      #1;
      n_tests++;
      if (datA_out !== tbl[a] || datB_out !== tbl[7 - a]) begin
        n_fail++; $display("FAIL init_table a=%0d got=%h/%h exp=%h/%h", a, datA_out, datB_out, tbl[a], tbl[7 - a]);
      end
    end
  endtask

  task automatic test_init_write_drop();
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd_addrA = 3'd2;
    for (int k = 1; k <= 8; k++) begin
      wr_en = (k == 3); wr_addr = 3'd2; dat_in = 8'hAA;
      #1;
      n_tests++;
      if (datA_out !== 8'd0) begin n_fail++; $display("FAIL init_datA k=%0d got=%h exp=00", k, datA_out); end
      @(negedge clk);
      n_tests++;
      if (wr_drop !== (k == 3)) begin n_fail++; $display("FAIL init_drop k=%0d got=%b exp=%b", k, wr_drop, k == 3); end
    end
    wr_en = 1'b0;
    #1;
    n_tests++;
    if (datA_out !== 8'h02) begin n_fail++; $display("FAIL init_drop_r2 got=%h exp=02", datA_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_tests++;
      if (ready !== m_ready || wr_drop !== m_drop) begin
        n_fail++; $display("FAIL rand_flags i=%0d got=%b/%b exp=%b/%b", i, ready, wr_drop, m_ready, m_drop);
      end
      reset    = ($urandom_range(0, 63) == 0);
      wr_en    = 1'($urandom);
      wr_addr  = 3'($urandom);
      dat_in   = 8'($urandom);
      rd_addrA = 3'($urandom);
      rd_addrB = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
      #1;
      n_tests++;
      if (datA_out !== exp_rd(rd_addrA) || datB_out !== exp_rd(rd_addrB)) begin
        n_fail++; $display("FAIL rand_read i=%0d got=%h/%h exp=%h/%h", i, datA_out, datB_out, exp_rd(rd_addrA), exp_rd(rd_addrB));
      end
    end
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_same_cycle_rw();
    logic [7:0] exp;
    do_init();
    wr_en = 1'b1; wr_addr = 3'd7; dat_in = 8'h5C; rd_addrA = 3'd7;
    exp = BYP ? 8'h5C : 8'h00;
    #1;
    n_tests++;
    if (datA_out !== exp) begin n_fail++; $display("FAIL same_cycle got=%h exp=%h", datA_out, exp); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    n_tests++;
    if (datA_out !== 8'h5C) begin n_fail++; $display("FAIL next_cycle got=%h exp=5c", datA_out); end
  endtask

  task automatic test_dual_port();
    do_init();
    rd_addrA = 3'd3; rd_addrB = 3'd3;
    #1;
    n_tests++;
    if (datA_out !== 8'h03 || datB_out !== 8'h03) begin
      n_fail++; $display("FAIL dual_init got=%h/%h exp=03/03", datA_out, datB_out);
    end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd3; dat_in = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    n_tests++;
    if (datA_out !== 8'hFF || datB_out !== 8'hFF) begin
      n_fail++; $display("FAIL dual_write got=%h/%h exp=ff/ff", datA_out, datB_out);
    end
  endtask

  task automatic test_reset_mid_init();
    do_init();
    wr_en = 1'b1; wr_addr = 3'd5; dat_in = 8'h77;
    @(negedge clk);
    wr_en = 1'b0; rd_addrA = 3'd5;
    #1;
    n_tests++;
    if (datA_out !== 8'h77) begin n_fail++; $display("FAIL mid_r5_write got=%h exp=77", datA_out); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_tests++;
      if (ready !== (k == 8)) begin n_fail++; $display("FAIL mid_ready k=%0d got=%b exp=%b", k, ready, k == 8); end
    end
    #1;
    n_tests++;
    if (datA_out !== 8'h05) begin n_fail++; $display("FAIL mid_r5_reinit got=%h exp=05", datA_out); end
  endtask

  task automatic test_zero_r0();
    @(negedge clk);
    z_reset = 1'b1; z_wr_en = 1'b0;
    @(negedge clk);
    z_reset = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (z_ready !== 1'b1) begin n_fail++; $display("FAIL z_ready got=%b exp=1", z_ready); end
    z_rd_a = 3'd0; z_rd_b = 3'd1;
    #1;
    n_tests++;
    if (z_datA !== 8'h00 || z_datB !== 8'h01) begin
      n_fail++; $display("FAIL z_init got=%h/%h exp=00/01", z_datA, z_datB);
    end
    @(negedge clk);
    z_wr_en = 1'b1; z_wr_addr = 3'd0; z_dat_in = 8'h12;
    #1;
    n_tests++;
    if (z_datA !== 8'h00) begin n_fail++; $display("FAIL z_r0_same got=%h exp=00", z_datA); end
    @(negedge clk);
    z_wr_en = 1'b1; z_wr_addr = 3'd4; z_dat_in = 8'h34;
    #1;
    n_tests++;
    if (z_drop !== 1'b1 || z_datA !== 8'h00) begin
      n_fail++; $display("FAIL z_r0_drop got=%b/%h exp=1/00", z_drop, z_datA);
    end
    @(negedge clk);
    z_wr_en = 1'b0; z_rd_b = 3'd4;
    #1;
    n_tests++;
    if (z_drop !== 1'b0 || z_datB !== 8'h34 || z_datA !== 8'h00) begin
      n_fail++; $display("FAIL z_r4_write got=%b/%h/%h exp=0/34/00", z_drop, z_datB, z_datA);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; dat_in = '0; rd_addrA = '0; rd_addrB = '0;
    z_reset = 1'b1; z_wr_en = 1'b0; z_wr_addr = '0; z_dat_in = '0; z_rd_a = '0; z_rd_b = '0;
    test_reset();
    test_init_write_drop();
    test_random();
    test_same_cycle_rw();
    test_dual_port();
    test_reset_mid_init();
    test_zero_r0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
